// File: rtl/nibble_sub_clk_pkg.sv
// Shared definitions for the clocked nibble-serial subtractor.
//   state_e : FSM state encodings (IDLE / RUN / DONE)
//   SLICE   : width of the datapath slice processed per clock
package nibble_sub_clk_pkg;

  localparam int SLICE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa.sv
// Single-bit full-adder cell.
//   a, b, ci : addend bits and carry in
//   s, co    : sum bit and carry out
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rcs4.sv
// 4-bit ripple subtract slice: s = a + ~b + ci, built from four fa cells.
// With ci=1 on the lowest slice this is a - b in two's complement;
// co=1 means "no borrow" out of this slice.
//   a[3:0], b[3:0] : minuend / subtrahend slice
//   ci             : carry in (inverted borrow)
//   s[3:0], co     : difference slice and carry out
module rcs4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (~b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[4];

endmodule

// File: rtl/nibble_sub_clk.sv
// Clocked multi-word subtractor: d = a - b (mod 2^WIDTH), one 4-bit slice
// per clock, borrow carried between slices in a register.
//   clk, reset_n : clock (rising edge), async active-low reset
//   start        : request, accepted in IDLE or DONE
//   a, b         : operands, latched on an accepted start
//   busy         : high while RUN
//   done         : one-cycle pulse, d/bo/ov valid
//   d, bo, ov    : difference, borrow out (a < b unsigned), signed overflow
//   dbg_state    : current FSM state encoding
//
// Handshake: start is a request sampled on the rising edge; it is accepted
// only when busy=0 (IDLE or DONE). An accepted start latches a and b; start
// seen while busy is dropped, never queued. done pulses exactly one cycle
// NIB+1 edges after acceptance and results hold until the next acceptance.
module nibble_sub_clk
  import nibble_sub_clk_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ov,
  output logic [1:0]       dbg_state
);

  localparam int NIB = WIDTH / SLICE;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             accept;
  logic [SLICE-1:0] a_sl, b_sl, s_sl;
  logic             co_sl;

  assign a_sl = a_q[int'(idx) * SLICE +: SLICE];
  assign b_sl = b_q[int'(idx) * SLICE +: SLICE];

  rcs4 u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .ci (carry),
    .s  (s_sl),
    .co (co_sl)
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (idx == LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b1;
      d     <= '0;
      bo    <= 1'b0;
      ov    <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      idx   <= '0;
      carry <= 1'b1;  // the +1 of two's-complement negation of b
      bo    <= 1'b0;
      ov    <= 1'b0;
    end else if (state == ST_RUN) begin
      d[int'(idx) * SLICE +: SLICE] <= s_sl;
      carry <= co_sl;
      idx   <= idx + IW'(1);
      if (idx == LAST) begin
        // Final slice: its top bit is the result MSB, so flags are
        // resolved here and are stable throughout the DONE cycle.
        bo <= ~co_sl;
        ov <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s_sl[SLICE-1] != a_q[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_nibble_sub_clk.sv
// Bench for nibble_sub_clk at WIDTH=32 and WIDTH=4.
module tb_nibble_sub_clk;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        start32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, d32;
  logic        busy32, done32, bo32, ov32;
  logic [1:0]  st32;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0, d4;
  logic        busy4, done4, bo4, ov4;
  logic [1:0]  st4;

  int n_checks = 0;
  int n_errors = 0;
  int n_done32 = 0;
  int exp_done32 = 0;

  logic [33:0] exp_q32[$];
  logic [5:0]  exp_q4[$];

  // clock / reset
  always #5 clk = ~clk;

  nibble_sub_clk #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .d(d32), .bo(bo32), .ov(ov32),
    .dbg_state(st32)
  );

  nibble_sub_clk #(.WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .d(d4), .bo(bo4), .ov(ov4),
    .dbg_state(st4)
  );

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: {d, bo, ov}
  function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    r = x - y;
    return {r, (x < y), (x[31] != y[31]) && (r[31] != x[31])};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] r;
    r = x - y;
    return {r, (x < y), (x[3] != y[3]) && (r[3] != x[3])};
  endfunction

  // scoreboards: pop and compare on every done pulse
  always @(negedge clk) begin
    if (done32) begin
      logic [33:0] e;
      n_done32++;
      if (exp_q32.size() == 0) check("done32_unexpected", 34'd1, 34'd0);
      else begin
        e = exp_q32.pop_front();
        check("d32", {2'b0, d32}, {2'b0, e[33:2]});
        check("bo32", {33'b0, bo32}, {33'b0, e[1]});
        check("ov32", {33'b0, ov32}, {33'b0, e[0]});
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      logic [5:0] e;
      if (exp_q4.size() == 0) check("done4_unexpected", 34'd1, 34'd0);
      else begin
        e = exp_q4.pop_front();
        check("d4", {30'b0, d4}, {30'b0, e[5:2]});
        check("bo4", {33'b0, bo4}, {33'b0, e[1]});
        check("ov4", {33'b0, ov4}, {33'b0, e[0]});
      end
    end
  end

  // driver tasks: called #1 after a rising edge
  task automatic issue32(input logic [31:0] x, input logic [31:0] y, input bit hold);
    a32 = x; b32 = y; start32 = 1'b1;
    exp_q32.push_back(model32(x, y));
    exp_done32++;
    @(posedge clk); #1;
    if (hold) a32 = 32'hFFFF_FFFF;
    else start32 = 1'b0;
  endtask

  task automatic wait_done32(output int cyc);
    cyc = 0;
    while (!done32 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run32(input logic [31:0] x, input logic [31:0] y);
    int cyc;
    issue32(x, y, 1'b0);
    wait_done32(cyc);
    check("lat32", 34'(cyc), 34'd8);
    @(posedge clk); #1;
  endtask

  task automatic run4(input logic [3:0] x, input logic [3:0] y);
    int cyc;
    a4 = x; b4 = y; start4 = 1'b1;
    exp_q4.push_back(model4(x, y));
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 1;
    while (!done4 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("lat4", 34'(cyc), 34'd2);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    logic [31:0] ta[4];
    logic [31:0] tb[4];
    ta = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    tb = '{32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};

    #1;
    check("rst_busy", {33'b0, busy32}, 34'd0);
    check("rst_done", {33'b0, done32}, 34'd0);
    check("rst_d", {2'b0, d32}, 34'd0);
    check("rst_flags", {32'b0, bo32, ov32}, 34'd0);
    check("rst_state", {32'b0, st32}, 34'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    run32(32'h5, 32'h3);
    run32(32'h3, 32'h5);
    // results hold after done
    repeat (3) @(posedge clk);
    #1;
    check("hold_d", {2'b0, d32}, {2'b0, 32'hFFFF_FFFE});
    check("hold_bo", {33'b0, bo32}, 34'd1);
    run32(32'h8000_0000, 32'h1);

    // start held through RUN with new operands: ignored
    issue32(32'h5, 32'h3, 1'b1);
    check("run_state", {32'b0, st32}, 34'd1);
    check("run_busy", {33'b0, busy32}, 34'd1);
    wait_done32(cyc);
    start32 = 1'b0;
    check("lat_hold", 34'(cyc), 34'd8);
    @(posedge clk); #1;
    check("idle_after", {32'b0, st32}, 34'd0);

    // back-to-back accept in the DONE cycle
    issue32(32'h7, 32'h9, 1'b0);
    wait_done32(cyc);
    issue32(32'h10, 32'h10, 1'b0);
    check("b2b_flags_clr", {32'b0, bo32, ov32}, 34'd0);
    wait_done32(cyc);
    check("lat_b2b", 34'(cyc), 34'd8);
    @(posedge clk); #1;

    // reset during the 4th RUN cycle
    issue32(32'h5, 32'h3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_q32.delete();
    exp_done32--;
    #1;
    check("arst_busy", {33'b0, busy32}, 34'd0);
    check("arst_done", {33'b0, done32}, 34'd0);
    check("arst_d", {2'b0, d32}, 34'd0);
    check("arst_flags", {32'b0, bo32, ov32}, 34'd0);
    check("arst_state", {32'b0, st32}, 34'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    run32(32'h5, 32'h3);

    // boundary table and random operands
    for (int i = 0; i < 4; i++) run32(ta[i], tb[i]);
    for (int i = 0; i < 6; i++) run32($urandom, $urandom);

    // WIDTH=4 instance
    run4(4'h2, 4'h7);
    run4(4'h8, 4'h1);
    for (int i = 0; i < 6; i++) run4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    repeat (3) @(posedge clk);
    #1;
    check("q32_empty", 34'(exp_q32.size()), 34'd0);
    check("q4_empty", 34'(exp_q4.size()), 34'd0);
    check("done32_count", 34'(n_done32), 34'(exp_done32));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
